// File: rtl/cpu_bus_master.sv
// cpu_bus_master: splits one CORE_DW core transfer into little-endian BUS_DW bus beats,
// each driven as setup / strobe / hold. Define BUS_TIMEOUT_EN to enable the per-beat strobe timeout.
module cpu_bus_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int BUS_DW         = 8,
    parameter int CORE_DW        = 32,
    parameter int STROBE_CYCLES  = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [CORE_DW-1:0]    i_wdata,
    output logic                  o_busy,
    output logic                  o_ack,
    output logic                  o_err,
    output logic [CORE_DW-1:0]    o_rdata,
    output logic                  o_bus_clk,
    output logic                  o_bus_we,
    output logic [ADDR_WIDTH-1:0] o_bus_addr,
    output logic [BUS_DW-1:0]     o_bus_data,
    input  logic [BUS_DW-1:0]     i_bus_data,
    input  logic                  i_bus_data_ready
);

    localparam int NBEATS  = CORE_DW / BUS_DW;
    localparam int BEAT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int CNT_MAX = (TIMEOUT_CYCLES > STROBE_CYCLES) ? TIMEOUT_CYCLES : STROBE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(NBEATS - 1);
    localparam logic [CNT_W-1:0]  STROBE_LIM = CNT_W'(STROBE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_SAT    = CNT_W'(CNT_MAX);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_DONE
    } state_t;

    state_t              state;
    state_t              next_state;
    logic                we_q;
    logic [CORE_DW-1:0]  wdata_q;
    logic [BEAT_W-1:0]   beat;
    logic [BEAT_W-1:0]   next_beat;
    logic [CNT_W-1:0]    strobe_cnt;
    logic                abort_q;
    logic                ready_ok;
    logic                timeout_hit;

    // Ready only counts once the strobe has been high for STROBE_CYCLES cycles.
    assign ready_ok  = (strobe_cnt >= STROBE_LIM) && i_bus_data_ready;
    assign next_beat = beat + BEAT_W'(1);

`ifdef BUS_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);
    // A ready honoured on the timeout cycle itself wins over the abort.
    assign timeout_hit = (strobe_cnt >= TIMEOUT_LIM) && !ready_ok;
`else
    assign timeout_hit = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (i_req) next_state = ST_SETUP;
            ST_SETUP:  next_state = ST_STROBE;
            ST_STROBE: if (ready_ok || timeout_hit) next_state = ST_HOLD;
            ST_HOLD:   next_state = (beat == LAST_BEAT || abort_q) ? ST_DONE : ST_SETUP;
            ST_DONE:   next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Control outputs decode straight from state so a synchronous reset drops them on the same edge.
    always_comb begin
        o_busy    = (state != ST_IDLE);
        o_ack     = (state == ST_DONE);
        o_bus_clk = (state == ST_STROBE);
        o_bus_we  = we_q && ((state == ST_SETUP) || (state == ST_STROBE));
`ifdef BUS_TIMEOUT_EN
        o_err     = (state == ST_DONE) && abort_q;
`else
        o_err     = 1'b0;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            beat       <= '0;
            strobe_cnt <= '0;
            abort_q    <= 1'b0;
            o_bus_addr <= '0;
            o_bus_data <= '0;
            o_rdata    <= '0;
        end else begin
            state <= next_state;
            case (state)
                ST_IDLE: begin
                    if (i_req) begin
                        we_q       <= i_we;
                        wdata_q    <= i_wdata;
                        beat       <= '0;
                        abort_q    <= 1'b0;
                        o_bus_addr <= i_addr;
                        o_bus_data <= i_wdata[BUS_DW-1:0];
                        o_rdata    <= '0;
                    end
                end
                ST_SETUP: begin
                    strobe_cnt <= CNT_W'(1);
                end
                ST_STROBE: begin
                    if (ready_ok && !we_q) begin
                        o_rdata[beat*BUS_DW +: BUS_DW] <= i_bus_data;
                    end
                    if (timeout_hit) begin
                        abort_q <= 1'b1;
                    end
                    if (strobe_cnt != CNT_SAT) begin
                        strobe_cnt <= strobe_cnt + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    // Address wraps naturally modulo 2^ADDR_WIDTH.
                    if (next_state == ST_SETUP) begin
                        beat       <= next_beat;
                        o_bus_addr <= o_bus_addr + ADDR_WIDTH'(1);
                        o_bus_data <= wdata_q[next_beat*BUS_DW +: BUS_DW];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_bus_master.sv
// Scoreboard bench for cpu_bus_master: stimulus pushes expected beats/acks, a negedge monitor pops and compares.
// Two instances: u_dut_a (STROBE_CYCLES=1, TIMEOUT_CYCLES=4) and u_dut_b (STROBE_CYCLES=3).
module tb_cpu_bus_master;

    typedef struct {
        int          d;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } resp_t;

    typedef struct {
        int          d;
        logic [31:0] addr;
        logic [7:0]  data;
        logic        we;
        int          len;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst     [2];
    logic        req     [2];
    logic        we_i    [2];
    logic [31:0] addr_i  [2];
    logic [31:0] wdata_i [2];
    logic        busy    [2];
    logic        ack     [2];
    logic        err     [2];
    logic [31:0] rdata   [2];
    logic        bclk    [2];
    logic        bwe     [2];
    logic [31:0] baddr   [2];
    logic [7:0]  bdata   [2];
    logic [7:0]  bdin    [2];
    logic        brdy    [2] = '{1'b1, 1'b1};

    resp_t resp_q[$];
    beat_t beat_q[$];
    bit    mon_en   = 1'b0;
    bit    tmo_mode = 1'b0;
    bit    stall_en = 1'b0;
    logic [31:0] stall_addr = 32'h0;
    int    n_strobe [2] = '{0, 0};
    int    t_ack    [3];

    cpu_bus_master #(.ADDR_WIDTH(32), .BUS_DW(8), .CORE_DW(32), .STROBE_CYCLES(1), .TIMEOUT_CYCLES(4)) u_dut_a (
        .i_clk(clk), .i_rst(rst[0]), .i_req(req[0]), .i_we(we_i[0]), .i_addr(addr_i[0]), .i_wdata(wdata_i[0]),
        .o_busy(busy[0]), .o_ack(ack[0]), .o_err(err[0]), .o_rdata(rdata[0]),
        .o_bus_clk(bclk[0]), .o_bus_we(bwe[0]), .o_bus_addr(baddr[0]), .o_bus_data(bdata[0]),
        .i_bus_data(bdin[0]), .i_bus_data_ready(brdy[0])
    );

    cpu_bus_master #(.ADDR_WIDTH(32), .BUS_DW(8), .CORE_DW(32), .STROBE_CYCLES(3), .TIMEOUT_CYCLES(255)) u_dut_b (
        .i_clk(clk), .i_rst(rst[1]), .i_req(req[1]), .i_we(we_i[1]), .i_addr(addr_i[1]), .i_wdata(wdata_i[1]),
        .o_busy(busy[1]), .o_ack(ack[1]), .o_err(err[1]), .o_rdata(rdata[1]),
        .o_bus_clk(bclk[1]), .o_bus_we(bwe[1]), .o_bus_addr(baddr[1]), .o_bus_data(bdata[1]),
        .i_bus_data(bdin[1]), .i_bus_data_ready(brdy[1])
    );

    // Device model: the byte returned depends only on the low two address bits (11,22,33,44).
    function automatic logic [7:0] dev_byte(input logic [31:0] a);
        case (a[1:0])
            2'd0:    return 8'h11;
            2'd1:    return 8'h22;
            2'd2:    return 8'h33;
            default: return 8'h44;
        endcase
    endfunction

    assign bdin[0] = dev_byte(baddr[0]);
    assign bdin[1] = dev_byte(baddr[1]);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Ready driver: sc counts strobe cycles so far in the current beat (1 during the first one).
    int sc [2] = '{0, 0};
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) sc[d] = bclk[d] ? sc[d] + 1 : 0;
        brdy[0] = !tmo_mode;
        brdy[1] = !(stall_en && bclk[1] && baddr[1] == stall_addr && sc[1] < 8);
    end

    // Monitor: latency counts cycles from the accept edge through the end of the ack cycle.
    int    start_cyc [2];
    int    hi_cnt    [2];
    int    cur_len   [2];
    logic  prev_busy [2] = '{1'b0, 1'b0};
    logic  prev_bclk [2] = '{1'b0, 1'b0};
    always @(negedge clk) begin
        beat_t b;
        resp_t r;
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                if (busy[d] && !prev_busy[d]) start_cyc[d] = cyc;
                if (busy[d] && !bclk[d] && !prev_bclk[d] && !ack[d] && beat_q.size() > 0) begin
                    check("setup_bus_we", bwe[d], beat_q[0].we);
                    check("setup_bus_addr", baddr[d], beat_q[0].addr);
                end
                if (bclk[d] && !prev_bclk[d]) begin
                    n_strobe[d]++;
                    hi_cnt[d] = 0;
                    n_checks++;
                    if (beat_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_strobe: dut %0d addr 0x%0h, expected none", d, baddr[d]);
                        cur_len[d] = 0;
                    end else begin
                        b = beat_q.pop_front();
                        cur_len[d] = b.len;
                        check("beat_dut", d, b.d);
                        check("beat_addr", baddr[d], b.addr);
                        check("beat_data", bdata[d], b.data);
                        check("beat_we", bwe[d], b.we);
                    end
                end
                if (bclk[d]) hi_cnt[d]++;
                if (!bclk[d] && prev_bclk[d]) begin
                    check("hold_bus_we", bwe[d], 0);
                    if (cur_len[d] != 0) check("strobe_len", hi_cnt[d], cur_len[d]);
                end
                if (ack[d]) begin
                    check("done_bus_we", bwe[d], 0);
                    n_checks++;
                    if (resp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_ack: dut %0d rdata 0x%0h, expected no ack", d, rdata[d]);
                    end else begin
                        r = resp_q.pop_front();
                        check("ack_dut", d, r.d);
                        check("ack_rdata", rdata[d], r.rdata);
                        check("ack_err", err[d], r.err);
                        check("ack_latency", cyc - start_cyc[d] + 1, r.lat);
                    end
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            prev_busy[d] = busy[d];
            prev_bclk[d] = bclk[d];
        end
    end

    task automatic push_beats(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input int nb, input int stall_beat, input int len_norm, input int len_stall);
        beat_t b;
        for (int k = 0; k < nb; k++) begin
            b.d    = d;
            b.addr = addr + 32'(k);
            b.data = wdata[k*8 +: 8];
            b.we   = we;
            b.len  = (k == stall_beat) ? len_stall : len_norm;
            beat_q.push_back(b);
        end
    endtask

    task automatic push_resp(input int d, input logic [31:0] rd, input logic e, input int lat);
        resp_t r;
        r.d = d; r.rdata = rd; r.err = e; r.lat = lat;
        resp_q.push_back(r);
    endtask

    task automatic issue(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        req[d] = 1'b1; we_i[d] = we; addr_i[d] = addr; wdata_i[d] = wdata;
        @(negedge clk);
        req[d] = 1'b0; we_i[d] = 1'b0; addr_i[d] = 32'h0; wdata_i[d] = 32'h0;
    endtask

    task automatic wait_done(input int d, input int budget);
        int n = 0;
        while ((resp_q.size() != 0 || busy[d]) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_within_budget", (n < budget), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  n_ack;
        bit  found;
        int  strobes_before;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req[d] = 1'b0; we_i[d] = 1'b0; addr_i[d] = 32'h0; wdata_i[d] = 32'h0;
        end
        repeat (3) @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_busy", busy[d], 0);
            check("rst_ack", ack[d], 0);
            check("rst_err", err[d], 0);
            check("rst_bus_clk", bclk[d], 0);
            check("rst_bus_we", bwe[d], 0);
            check("rst_bus_addr", baddr[d], 0);
            check("rst_bus_data", bdata[d], 0);
            check("rst_rdata", rdata[d], 0);
        end
        mon_en = 1'b1;

        // Read at 0x1000, ready tied high: 4*(2+1)+1 = 13 cycles.
        push_beats(0, 1'b0, 32'h0000_1000, 32'h0, 4, -1, 1, 1);
        push_resp(0, 32'h4433_2211, 1'b0, 13);
        issue(0, 1'b0, 32'h0000_1000, 32'h0);
        wait_done(0, 40);

        // Write with address wrap across 0xFFFFFFFF.
        push_beats(0, 1'b1, 32'hFFFF_FFFE, 32'hDEAD_BEEF, 4, -1, 1, 1);
        push_resp(0, 32'h0, 1'b0, 13);
        issue(0, 1'b1, 32'hFFFF_FFFE, 32'hDEAD_BEEF);
        wait_done(0, 40);

        // STROBE_CYCLES=3: 4*(2+3)+1 = 21 cycles, then 5 extra stall cycles on beat 1 gives 26.
        push_beats(1, 1'b0, 32'h0000_1000, 32'h0, 4, -1, 3, 3);
        push_resp(1, 32'h4433_2211, 1'b0, 21);
        issue(1, 1'b0, 32'h0000_1000, 32'h0);
        wait_done(1, 60);
        stall_en   = 1'b1;
        stall_addr = 32'h0000_1001;
        push_beats(1, 1'b0, 32'h0000_1000, 32'h0, 4, 1, 3, 8);
        push_resp(1, 32'h4433_2211, 1'b0, 26);
        issue(1, 1'b0, 32'h0000_1000, 32'h0);
        wait_done(1, 60);
        stall_en = 1'b0;

        // Reset during STROBE of beat 2: no ack, outputs drop on the next edge, partial read data cleared.
        push_beats(0, 1'b0, 32'h0000_2000, 32'h0, 3, 2, 1, 0);
        issue(0, 1'b0, 32'h0000_2000, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bclk[0] && baddr[0] == 32'h0000_2002) begin
                found = 1'b1;
                break;
            end
        end
        check("reached_beat2_strobe", found, 1);
        rst[0] = 1'b1;
        @(posedge clk);
        #1;
        check("abort_bus_clk", bclk[0], 0);
        check("abort_busy", busy[0], 0);
        check("abort_ack", ack[0], 0);
        check("abort_bus_we", bwe[0], 0);
        check("abort_rdata", rdata[0], 0);
        @(negedge clk);
        rst[0] = 1'b0;
        push_beats(0, 1'b0, 32'h0000_3000, 32'h0, 4, -1, 1, 1);
        push_resp(0, 32'h4433_2211, 1'b0, 13);
        issue(0, 1'b0, 32'h0000_3000, 32'h0);
        wait_done(0, 40);

        // i_req held high: three transfers, acks 13 + 1 IDLE = 14 cycles apart.
        for (int k = 0; k < 3; k++) begin
            push_beats(0, 1'b0, 32'h0000_1000, 32'h0, 4, -1, 1, 1);
            push_resp(0, 32'h4433_2211, 1'b0, 13);
        end
        @(negedge clk);
        req[0] = 1'b1; we_i[0] = 1'b0; addr_i[0] = 32'h0000_1000; wdata_i[0] = 32'h0;
        n_ack = 0;
        for (int i = 0; i < 100 && n_ack < 3; i++) begin
            @(negedge clk);
            if (ack[0]) begin
                t_ack[n_ack] = cyc;
                n_ack++;
                if (n_ack == 3) req[0] = 1'b0;
            end
        end
        req[0] = 1'b0;
        check("held_req_ack_count", n_ack, 3);
        check("ack_spacing_0_1", t_ack[1] - t_ack[0], 14);
        check("ack_spacing_1_2", t_ack[2] - t_ack[1], 14);
        wait_done(0, 40);

`ifdef BUS_TIMEOUT_EN
        // Ready never comes on beat 0: 1+4+1+1 = 7 cycles, err set, a single strobe.
        tmo_mode = 1'b1;
        strobes_before = n_strobe[0];
        push_beats(0, 1'b0, 32'h0000_4000, 32'h0, 1, -1, 4, 4);
        push_resp(0, 32'h0, 1'b1, 7);
        issue(0, 1'b0, 32'h0000_4000, 32'h0);
        wait_done(0, 40);
        check("timeout_strobe_count", n_strobe[0] - strobes_before, 1);
        tmo_mode = 1'b0;
`else
        strobes_before = n_strobe[0];
`endif

        repeat (3) @(negedge clk);
        check("resp_queue_empty", resp_q.size(), 0);
        check("beat_queue_empty", beat_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
